// File: rtl/instruction_dumper_pkg.sv
// Shared types and constants for the instruction memory readback path.
package instruction_dumper_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = WORD_W / BYTE_W;
  localparam int unsigned BYTE_IDX_W = 2;

  localparam logic [WORD_W-1:0] TERMINATOR_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_TERM  = 3'd4,
    S_DONE  = 3'd5
  } dump_state_e;

endpackage

// File: rtl/instruction_dumper_word_byte_serializer.sv
// Splits a 32-bit word into bytes, MSB first; load has priority over push.
module instruction_dumper_word_byte_serializer
  import instruction_dumper_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              push,
  output logic [BYTE_W-1:0] byte_out,
  output logic              last_byte_c
);

  logic [WORD_W-1:0]     shift_q;
  logic [BYTE_IDX_W-1:0] byte_idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else if (load) begin
      shift_q    <= load_data;
      byte_idx_q <= '0;
    end else if (push) begin
      shift_q    <= {shift_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
      byte_idx_q <= byte_idx_q + BYTE_IDX_W'(1);
    end
  end

  assign byte_out    = shift_q[WORD_W-1 -: BYTE_W];
  assign last_byte_c = (byte_idx_q == BYTE_IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/instruction_dumper.sv
// Reads a range of instruction memory and streams each word MSB-first into the UART tx FIFO.
module instruction_dumper
  import instruction_dumper_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter bit          SEND_TERMINATOR = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [WORD_W-1:0]     read_data,
  input  logic                  tx_full,
  output logic                  tx_send_enable,
  output logic [BYTE_W-1:0]     tx_send_data
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  dump_state_e       state_q, state_d;
  logic [CNT_W-1:0]  remaining_q;
  logic              push_c;
  logic              word_end_c;
  logic              last_word_c;
  logic              ser_load_c;
  logic [WORD_W-1:0] ser_data_c;
  logic              last_byte_c;

  assign last_word_c = (remaining_q == CNT_W'(1));

  // State register; busy/done registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != S_IDLE) && (state_d != S_DONE);
      done    <= (state_d == S_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count == '0) state_d = SEND_TERMINATOR ? S_TERM : S_DONE;
          else                  state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: state_d = S_SEND;
      S_SEND: begin
        if (word_end_c) begin
          if (last_word_c) state_d = SEND_TERMINATOR ? S_TERM : S_DONE;
          else             state_d = S_FETCH;
        end
      end
      S_TERM: begin
        if (push_c && last_byte_c) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Push strobe and serializer loads; the terminator load also covers the zero-word case.
  always_comb begin
    tx_send_enable = 1'b0;
    push_c         = 1'b0;
    word_end_c     = 1'b0;
    ser_load_c     = 1'b0;
    ser_data_c     = read_data;
    unique case (state_q)
      S_IDLE: begin
        if (start && (word_count == '0) && SEND_TERMINATOR) begin
          ser_load_c = 1'b1;
          ser_data_c = TERMINATOR_WORD;
        end
      end
      S_LATCH: ser_load_c = 1'b1;
      S_SEND: begin
        tx_send_enable = !tx_full;
        push_c         = !tx_full;
        word_end_c     = push_c && last_byte_c;
        if (word_end_c && last_word_c && SEND_TERMINATOR) begin
          ser_load_c = 1'b1;
          ser_data_c = TERMINATOR_WORD;
        end
      end
      S_TERM: begin
        tx_send_enable = !tx_full;
        push_c         = !tx_full;
      end
      default: ;
    endcase
  end

  // Address and remaining-word counters; read_address wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_address <= '0;
      remaining_q  <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      read_address <= start_address;
      remaining_q  <= word_count;
    end else if (word_end_c) begin
      read_address <= read_address + ADDR_WIDTH'(1);
      remaining_q  <= remaining_q - CNT_W'(1);
    end
  end

  instruction_dumper_word_byte_serializer u_serializer (
    .clk         (clk),
    .reset       (reset),
    .load        (ser_load_c),
    .load_data   (ser_data_c),
    .push        (push_c),
    .byte_out    (tx_send_data),
    .last_byte_c (last_byte_c)
  );

endmodule

// File: tb/tb_instruction_dumper.sv
// Bench for instruction_dumper: byte-stream model from memory contents, two terminator settings.
module tb_instruction_dumper;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          start_nt = 1'b0;
  logic [AW-1:0] start_address = '0;
  logic [AW:0]   word_count = '0;
  logic          tx_full = 1'b0;
  logic          rnd_full = 1'b0;

  logic          busy, done, tx_send_enable;
  logic [AW-1:0] read_address;
  logic [31:0]   read_data;
  logic [7:0]    tx_send_data;
  logic          busy_nt, done_nt, tx_send_enable_nt;
  logic [AW-1:0] read_address_nt;
  logic [31:0]   read_data_nt;
  logic [7:0]    tx_send_data_nt;

  logic [31:0] mem [0:65535];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_nt_q[$];
  logic [7:0]  lit1 [12] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                             8'hDE, 8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int done_nt_cnt = 0;
  int exp_done_nt = 0;

  instruction_dumper #(.ADDR_WIDTH(AW), .SEND_TERMINATOR(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .start_address(start_address),
    .word_count(word_count), .busy(busy), .done(done), .read_address(read_address),
    .read_data(read_data), .tx_full(tx_full), .tx_send_enable(tx_send_enable),
    .tx_send_data(tx_send_data)
  );

  instruction_dumper #(.ADDR_WIDTH(AW), .SEND_TERMINATOR(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .start(start_nt), .start_address(start_address),
    .word_count(word_count), .busy(busy_nt), .done(done_nt), .read_address(read_address_nt),
    .read_data(read_data_nt), .tx_full(tx_full), .tx_send_enable(tx_send_enable_nt),
    .tx_send_data(tx_send_data_nt)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data for an address appears one cycle later.
  always @(posedge clk) begin
    read_data    <= mem[read_address];
    read_data_nt <= mem[read_address_nt];
  end

  always @(posedge clk) begin
    #1;
    tx_full = rnd_full ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every pushed byte must be the next one the model predicts; done only once the stream is complete.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_send_enable) begin
        chk("enable_while_full", 32'(tx_full), 32'd0);
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(tx_send_data), 32'hFFFF_FFFF);
        else chk("byte", 32'(tx_send_data), 32'(exp_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_pending", exp_q.size(), 32'd0);
      end
      if (tx_send_enable_nt) begin
        chk("nt_enable_while_full", 32'(tx_full), 32'd0);
        if (exp_nt_q.size() == 0) chk("nt_unexpected_byte", 32'(tx_send_data_nt), 32'hFFFF_FFFF);
        else chk("nt_byte", 32'(tx_send_data_nt), 32'(exp_nt_q.pop_front()));
      end
      if (done_nt) begin
        done_nt_cnt++;
        chk("nt_done_busy", 32'(busy_nt), 32'd0);
        chk("nt_done_pending", exp_nt_q.size(), 32'd0);
      end
    end
  end

  task automatic do_start(input bit nt, input logic [AW-1:0] sa, input int wc);
    logic [AW-1:0] a;
    logic [31:0]   w;
    a = sa;
    for (int i = 0; i < wc; i++) begin
      w = mem[a];
      for (int b = 3; b >= 0; b--) begin
        if (nt) exp_nt_q.push_back(w[8*b +: 8]);
        else    exp_q.push_back(w[8*b +: 8]);
      end
      a = a + 16'd1;
    end
    if (nt) exp_done_nt++;
    else begin
      repeat (4) exp_q.push_back(8'hFF);
      exp_done++;
    end
    @(posedge clk); #1;
    start_address = sa;
    word_count    = 17'(wc);
    if (nt) start_nt = 1'b1;
    else    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    start_nt = 1'b0;
  endtask

  task automatic wait_done(input bit nt, input int budget);
    int n;
    n = 0;
    while (((nt ? done_nt_cnt : done_cnt) != (nt ? exp_done_nt : exp_done)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (nt) chk("nt_done_timeout", done_nt_cnt, exp_done_nt);
    else    chk("done_timeout", done_cnt, exp_done);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[0] = 32'h1234_5678;
    mem[1] = 32'h9ABC_DEF0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_enable", 32'(tx_send_enable), 32'd0);
    chk("rst_addr", 32'(read_address), 32'd0);
    chk("rst_data", 32'(tx_send_data), 32'd0);
    chk("rst_nt_enable", 32'(tx_send_enable_nt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Two words, no backpressure; pin the model and the first-byte latency.
    do_start(1'b0, 16'h0000, 2);
    for (int i = 0; i < 12; i++) chk("model_pin", 32'(exp_q[i]), 32'(lit1[i]));
    @(negedge clk);
    chk("fetch_busy", 32'(busy), 32'd1);
    chk("fetch_enable", 32'(tx_send_enable), 32'd0);
    chk("fetch_addr", 32'(read_address), 32'd0);
    @(negedge clk);
    chk("latch_enable", 32'(tx_send_enable), 32'd0);
    @(negedge clk);
    chk("first_enable", 32'(tx_send_enable), 32'd1);
    chk("first_byte", 32'(tx_send_data), 32'h12);
    wait_done(1'b0, 200);

    // Same transfer under random backpressure.
    rnd_full = 1'b1;
    do_start(1'b0, 16'h0000, 2);
    wait_done(1'b0, 500);
    rnd_full = 1'b0;

    // Zero words: terminator only, or immediate done without terminator.
    do_start(1'b0, 16'h0042, 0);
    chk("zero_wc_len", exp_q.size(), 32'd4);
    wait_done(1'b0, 100);
    do_start(1'b1, 16'h0042, 0);
    @(negedge clk);
    chk("nt_zero_done", 32'(done_nt), 32'd1);
    chk("nt_zero_busy", 32'(busy_nt), 32'd0);
    chk("nt_zero_enable", 32'(tx_send_enable_nt), 32'd0);
    wait_done(1'b1, 10);
    do_start(1'b1, 16'(($urandom)), 3);
    wait_done(1'b1, 200);

    // Address wrap.
    do_start(1'b0, 16'hFFFF, 2);
    @(negedge clk);
    chk("wrap_first_addr", 32'(read_address), 32'hFFFF);
    wait_done(1'b0, 200);
    chk("wrap_end_addr", 32'(read_address), 32'h0001);

    // Start pulses while busy are ignored.
    do_start(1'b0, 16'h1234, 3);
    repeat (3) begin
      @(posedge clk); #1;
      start = 1'b1; start_address = 16'(($urandom)); word_count = 17'd5;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(1'b0, 300);

    // Reset while the second byte of the first word is being pushed.
    do_start(1'b0, 16'h0100, 2);
    n = 0;
    while (exp_q.size() > 11 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach", exp_q.size(), 32'd11);
    reset = 1'b1;
    exp_q.delete();
    exp_done--;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_enable", 32'(tx_send_enable), 32'd0);
    chk("abort_addr", 32'(read_address), 32'd0);
    chk("abort_data", 32'(tx_send_data), 32'd0);
    do_start(1'b0, 16'h0200, 1);
    @(negedge clk);
    chk("replay_addr", 32'(read_address), 32'h0200);
    wait_done(1'b0, 200);

    // Randomized transfers with backpressure.
    rnd_full = 1'b1;
    for (int t = 0; t < 8; t++) begin
      do_start(1'b0, 16'(($urandom)), $urandom_range(0, 4));
      wait_done(1'b0, 600);
    end
    rnd_full = 1'b0;

    repeat (4) @(negedge clk);
    chk("final_done_count", done_cnt, exp_done);
    chk("final_nt_done_count", done_nt_cnt, exp_done_nt);
    chk("final_leftover", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
